// File: rtl/line_editor_if.sv
// line_editor_if: editor event inputs, the ready handshake, and the render/status outputs.
interface line_editor_if #(
  parameter int SYMBOL_WIDTH = 7,
  parameter int MAX_LEN = 32
);
  localparam int PW = $clog2(MAX_LEN + 1);
  logic left;
  logic right;
  logic backspace;
  logic [SYMBOL_WIDTH-1:0] symbol;
  logic ready;
  logic [PW-1:0] rd_addr;
  logic [SYMBOL_WIDTH-1:0] rd_symbol;
  logic [PW-1:0] length;
  logic [PW-1:0] cursor;
  logic changed;
  modport master (
    output left, right, backspace, symbol, rd_addr,
    input ready, rd_symbol, length, cursor, changed
  );
  modport slave (
    input left, right, backspace, symbol, rd_addr,
    output ready, rd_symbol, length, cursor, changed
  );
endinterface

// File: rtl/line_editor.sv
// line_editor: single-line symbol buffer with a cursor. Insert and delete shift the line one entry per cycle.
// Define LINE_EDITOR_WRAP_EN to make left/right wrap around at the ends; by default the cursor saturates.
module line_editor #(
  parameter int SYMBOL_WIDTH = 7,
  parameter int MAX_LEN = 32
) (
  input logic clk,
  input logic rst_n,
  line_editor_if.slave bus
);
  localparam int PW = $clog2(MAX_LEN + 1);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  typedef enum logic [1:0] {IDLE, INSERT, DELETE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] len_q, len_d, cur_q, cur_d, idx_q, idx_d;
  logic [SYMBOL_WIDTH-1:0] sym_q, sym_d, wd;
  logic chg_q, chg_d, we;
  logic [AW-1:0] wa;
  logic [SYMBOL_WIDTH-1:0] line_q [MAX_LEN];
  logic [PW-1:0] prev_idx, next_idx;
  assign prev_idx = idx_q - PW'(1);
  assign next_idx = idx_q + PW'(1);
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    cur_d = cur_q;
    idx_d = idx_q;
    sym_d = sym_q;
    chg_d = 1'b0;
    we = 1'b0;
    wa = idx_q[AW-1:0];
    wd = '0;
    case (state_q)
      IDLE: begin
        if (bus.left) begin
`ifdef LINE_EDITOR_WRAP_EN
          cur_d = cur_q != '0 ? cur_q - PW'(1) : len_q;
          chg_d = cur_q != '0 || len_q != '0;
`else
          cur_d = cur_q != '0 ? cur_q - PW'(1) : cur_q;
          chg_d = cur_q != '0;
`endif
        end else if (bus.right) begin
`ifdef LINE_EDITOR_WRAP_EN
          cur_d = cur_q != len_q ? cur_q + PW'(1) : '0;
          chg_d = cur_q != len_q || len_q != '0;
`else
          cur_d = cur_q != len_q ? cur_q + PW'(1) : cur_q;
          chg_d = cur_q != len_q;
`endif
        end else if (bus.backspace) begin
          if (cur_q != '0) begin
            idx_d = cur_q - PW'(1);
            state_d = DELETE;
          end
        end else if (bus.symbol != '0 && len_q != PW'(MAX_LEN)) begin
          sym_d = bus.symbol;
          idx_d = len_q;
          state_d = INSERT;
        end
      end
      // Ripple the tail right from the end until the gap reaches the cursor.
      INSERT: begin
        we = 1'b1;
        if (idx_q == cur_q) begin
          wd = sym_q;
          len_d = len_q + PW'(1);
          cur_d = cur_q + PW'(1);
          chg_d = 1'b1;
          state_d = IDLE;
        end else begin
          wd = line_q[prev_idx[AW-1:0]];
          idx_d = prev_idx;
        end
      end
      DELETE: begin
        we = 1'b1;
        if (idx_q == len_q - PW'(1)) begin
          len_d = len_q - PW'(1);
          cur_d = cur_q - PW'(1);
          chg_d = 1'b1;
          state_d = IDLE;
        end else begin
          wd = line_q[next_idx[AW-1:0]];
          idx_d = next_idx;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q <= '0;
      cur_q <= '0;
      idx_q <= '0;
      sym_q <= '0;
      chg_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) line_q[i] <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cur_q <= cur_d;
      idx_q <= idx_d;
      sym_q <= sym_d;
      chg_q <= chg_d;
      if (we) line_q[wa] <= wd;
    end
  end
  assign bus.ready = state_q == IDLE;
  assign bus.rd_symbol = bus.rd_addr < len_q ? line_q[bus.rd_addr[AW-1:0]] : '0;
  assign bus.length = len_q;
  assign bus.cursor = cur_q;
  assign bus.changed = chg_q;
endmodule

// File: tb/tb_line_editor.sv
// tb_line_editor: randomized and directed events checked against a queue-based line model.
module tb_line_editor;
  localparam int SW = 7;
  localparam int ML = 32;
  localparam int PW = $clog2(ML + 1);
`ifdef LINE_EDITOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #50 clk = ~clk;
  line_editor_if #(.SYMBOL_WIDTH(SW), .MAX_LEN(ML)) bus ();
  line_editor #(.SYMBOL_WIDTH(SW), .MAX_LEN(ML)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errors = 0;
  int checks = 0;
  int q[$];
  int mc = 0;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic sweep();
    check("length", int'(bus.length), q.size());
    check("cursor", int'(bus.cursor), mc);
    for (int a = 0; a <= ML; a++) begin
      bus.rd_addr = PW'(a);
      #1;
      check($sformatf("rd_symbol[%0d]", a), int'(bus.rd_symbol), a < q.size() ? q[a] : 0);
    end
  endtask
  task automatic ev(input bit l, input bit r, input bit b, input int s);
    int el, eb, busy;
    bit ec, done;
    el = q.size();
    eb = 0;
    ec = 1'b0;
    if (l) begin
      if (mc > 0) begin mc--; ec = 1'b1; end
      else if (WRAP && el > 0) begin mc = el; ec = 1'b1; end
    end else if (r) begin
      if (mc < el) begin mc++; ec = 1'b1; end
      else if (WRAP && el > 0) begin mc = 0; ec = 1'b1; end
    end else if (b) begin
      if (mc > 0) begin eb = el - mc + 1; q.delete(mc - 1); mc--; ec = 1'b1; end
    end else if (s != 0 && el < ML) begin
      eb = el - mc + 1;
      q.insert(mc, s);
      mc++;
      ec = 1'b1;
    end
    bus.left = l;
    bus.right = r;
    bus.backspace = b;
    bus.symbol = SW'(s);
    @(posedge clk);
    #1;
    bus.left = 1'b0;
    bus.right = 1'b0;
    bus.backspace = 1'b0;
    bus.symbol = '0;
    busy = 0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (bus.ready) done = 1'b1;
      else busy++;
    end
    if (!done) check("ready_timeout", 0, 1);
    check("busy_cycles", busy, eb);
    check("changed", int'(bus.changed), int'(ec));
    @(negedge clk);
    check("changed_width", int'(bus.changed), 0);
    sweep();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    mc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", int'(bus.ready), 1);
    @(negedge clk);
    check("changed_after_reset", int'(bus.changed), 0);
    sweep();
  endtask
  initial begin
    int k, s;
    bus.left = 1'b0;
    bus.right = 1'b0;
    bus.backspace = 1'b0;
    bus.symbol = '0;
    bus.rd_addr = '0;
    repeat (2) @(negedge clk);
    do_reset();
    ev(0, 0, 0, 'h61);
    ev(0, 0, 0, 'h62);
    ev(0, 0, 0, 'h63);
    ev(1, 0, 0, 0);
    ev(1, 0, 0, 0);
    ev(0, 0, 0, 'h78);
    ev(0, 0, 1, 0);
    ev(1, 0, 0, 0);
    ev(0, 0, 1, 0);
    ev(0, 0, 1, 0);
    ev(0, 1, 0, 0);
    ev(0, 1, 0, 0);
    ev(1, 0, 0, 'h41);
    ev(1, 0, 0, 0);
    ev(1, 0, 0, 0);
    ev(0, 1, 1, 'h42);
    while (q.size() < ML) ev(0, 0, 0, $urandom_range(1, 127));
    ev(0, 0, 0, 'h55);
    ev(0, 0, 0, 'h7f);
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      s = k >= 6 ? $urandom_range(1, 127) : 0;
      if ($urandom_range(0, 7) == 0) s = $urandom_range(0, 127);
      ev(k < 2, k == 2 || k == 3, k == 4 || k == 5 || k == 6, s);
    end
    do_reset();
    for (int n = 0; n < 10; n++) ev(0, 0, 0, $urandom_range(1, 127));
    for (int n = 0; n < 9; n++) ev(1, 0, 0, 0);
    bus.backspace = 1'b1;
    @(posedge clk);
    #1;
    bus.backspace = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_delete_busy", int'(bus.ready), 0);
    #10;
    rst_n = 1'b0;
    #1;
    check("async_len", int'(bus.length), 0);
    check("async_cursor", int'(bus.cursor), 0);
    check("async_ready", int'(bus.ready), 1);
    do_reset();
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      ev(k < 2, k == 2, k == 3 || k == 4, k >= 5 ? $urandom_range(1, 127) : 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/line_editor.md
LINE_EDITOR -- requirements
Module: line_editor

Interface
REQ-001 SHALL have parameter SYMBOL_WIDTH, default 7, symbol code width; code 0 means "no symbol".
REQ-002 SHALL have parameter MAX_LEN, default 32, line capacity in symbols; PW = $clog2(MAX_LEN+1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port left  input  1  move-cursor-left event.
REQ-006 SHALL have port right  input  1  move-cursor-right event.
REQ-007 SHALL have port backspace  input  1  delete-before-cursor event.
REQ-008 SHALL have port symbol  input  SYMBOL_WIDTH  insert-symbol event when nonzero.
REQ-009 SHALL have port ready  output  1  event accepted on any edge where event valid and ready high.
REQ-010 SHALL have port rd_addr  input  PW  render read address.
REQ-011 SHALL have port rd_symbol  output  SYMBOL_WIDTH  combinational line[rd_addr]; 0 when rd_addr >= length.
REQ-012 SHALL have port length  output  PW  symbols stored.
REQ-013 SHALL have port cursor  output  PW  cursor position, 0..length.
REQ-014 SHALL have port changed  output  1  one-cycle pulse after every completed edit or cursor move.

Function
REQ-015 Event valid = left | right | backspace | (symbol != 0); priority when several set: left > right > backspace > symbol; lower-priority bits of the same beat discarded.
REQ-016 States: IDLE, INSERT, DELETE; ready = 1 only in IDLE.
REQ-017 left in IDLE: cursor-1, completes same edge; at cursor 0 cursor unchanged, changed not pulsed.
REQ-018 right in IDLE: cursor+1, completes same edge; at cursor == length unchanged, changed not pulsed.
REQ-019 symbol in IDLE with length < MAX_LEN: latch symbol, idx <= length, go INSERT; with length == MAX_LEN: event consumed, no change, no pulse.
REQ-020 INSERT, idx > cursor: line[idx] <= line[idx-1], idx-1; idx == cursor: line[cursor] <= latched symbol, length+1, cursor+1, changed pulse, go IDLE. Occupies length-cursor+1 cycles.
REQ-021 backspace in IDLE with cursor > 0: idx <= cursor-1, go DELETE; with cursor == 0: consumed, no change, no pulse.
REQ-022 DELETE, idx < length-1: line[idx] <= line[idx+1], idx+1; idx == length-1: line[idx] <= 0, length-1, cursor-1, changed pulse, go IDLE. Occupies length-cursor+1 cycles.
REQ-023 Inputs ignored while ready is low; upstream holds them stable.
REQ-024 Invariant: 0 <= cursor <= length <= MAX_LEN; line[i] == 0 for all i >= length.
REQ-025 changed asserts the cycle after the completing edge, lasts exactly one cycle.
REQ-026 rd_symbol reflects registered contents, including mid-shift intermediate state.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, length 0, cursor 0, idx 0, changed 0, all line entries 0.
REQ-028 Reset mid-INSERT/DELETE aborts edit; no partial result survives.
REQ-029 ready = 1 on first edge after rst_n rises.

Configuration
REQ-030 Macro LINE_EDITOR_WRAP_EN defined: left at cursor 0 sets cursor = length; right at cursor == length sets cursor = 0; changed pulses if cursor value differs.
REQ-031 Macro undefined: saturating behaviour of REQ-017/REQ-018.

Verification
REQ-032 Reset, insert 'a'(0x61),'b'(0x62),'c'(0x63) -> length 3, cursor 3, rd 0..2 = 61,62,63, three changed pulses, each insert 1 INSERT cycle.
REQ-033 From "abc" cursor 3: left x2, insert 0x78 -> line "axbc", length 4, cursor 2, INSERT 3 cycles, ready low 3 cycles.
REQ-034 From "axbc" cursor 2: backspace -> "abc", cursor 1, line[3]=0, DELETE 3 cycles; backspace at cursor 0 -> no change, no pulse.
REQ-035 Fill MAX_LEN=32 symbols, insert 33rd -> length 32, contents unchanged, ready held 1.
REQ-036 left=1 and symbol=0x41 same beat at cursor 2 -> cursor 1, no insert; left at cursor 0 -> cursor 0 (no WRAP_EN) or cursor = length (WRAP_EN).
REQ-037 rst_n low during 10-cycle DELETE -> length 0, cursor 0, rd_symbol 0 all addresses, ready 1 after release.
